// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned UART_DEFAULT_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND
    } uart_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps at N.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int unsigned IdW = $clog2(N);

    logic        found;
    int unsigned idx;

    // The first requester at or after ptr (modulo N) wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Optional feature macro UART_TX_ARBITER_LOCK_EN adds per-requester lock bits
// so a producer can send an atomic multi-byte message.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_BITS      = UART_DEFAULT_DATA_BITS,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*DATA_BITS-1:0]   req_data,
`ifdef UART_TX_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]             req_lock,
`endif
    output logic [N_REQ-1:0]             req_ready,
    output logic [DATA_BITS-1:0]         uart_data,
    output logic                         uart_new_data,
    input  logic                         uart_ready,
    output logic                         busy,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         err
);

    localparam int unsigned IdW  = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = '1;

    uart_arb_state_e      state_q, state_d;
    logic [IdW-1:0]       ptr_q, ptr_d;
    logic [IdW-1:0]       grant_id_q, grant_id_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 lock_q, lock_d;

    logic [N_REQ-1:0]     arb_req, arb_gnt;
    logic [IdW-1:0]       arb_id;
    logic                 gnt_lock;

`ifdef UART_TX_ARBITER_LOCK_EN
    assign gnt_lock = req_lock[arb_id];
`else
    assign gnt_lock = 1'b0;
`endif

    // While locked, only the requester holding the lock may compete.
    assign arb_req = lock_q ? (req_valid & (N_REQ'(1) << grant_id_q)) : req_valid;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req    (arb_req),
        .ptr    (ptr_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    assign uart_data = data_q;
    assign grant_id  = grant_id_q;

    // State, pointer, captured byte, lock and timeout counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        lock_d        = lock_q;
        req_ready     = '0;
        uart_new_data = 1'b0;
        busy          = 1'b0;
        err           = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A busy UART blocks granting even with requests pending.
                if (uart_ready && (|arb_req)) begin
                    req_ready  = arb_gnt;
                    data_d     = req_data[int'(arb_id) * DATA_BITS +: DATA_BITS];
                    grant_id_d = arb_id;
                    lock_d     = gnt_lock;
                    if (!gnt_lock) begin
                        ptr_d = (arb_id == IdW'(N_REQ - 1)) ? '0 : arb_id + 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                uart_new_data = 1'b1;
                busy          = 1'b1;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!uart_ready) begin
                    state_d = SEND;
                end else if (cnt_q >= CntLast) begin
                    // UART never took the byte: drop it and release any lock.
                    err     = 1'b1;
                    lock_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (uart_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model and a simple UART model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned TO  = 8;
    localparam int unsigned IdW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   uart_data;
    logic            uart_new_data;
    logic            uart_ready = 1'b1;
    logic            busy;
    logic [IdW-1:0]  grant_id;
    logic            err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .DATA_BITS      (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
`ifdef UART_TX_ARBITER_LOCK_EN
        .req_lock      (req_lock),
`endif
        .req_ready     (req_ready),
        .uart_data     (uart_data),
        .uart_new_data (uart_new_data),
        .uart_ready    (uart_ready),
        .busy          (busy),
        .grant_id      (grant_id),
        .err           (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Producers: bytes still to send, current pending byte.
    int            p_left[N];
    logic [DW-1:0] p_data[N];
    int            withdraw_pct = 0;
    bit            rand_data = 0;
    bit            lock_mode = 0;
    bit            rand_mode = 0;

    // UART model: remaining busy cycles of the current frame, external stalls.
    bit            stall = 0;
    int            u_left = 0;
    int            ext_left = 0;
    int            len_min = 3;
    int            len_max = 3;
    logic [DW-1:0] u_log[$];

    // Reference model (transaction phases, not the RTL encoding).
    bit            m_free, m_wait, m_frame, m_lock;
    int            m_cnt, m_ptr, m_gid;
    logic [DW-1:0] m_byte;
    int            grants[$];
    int            n_drop = 0;
    bit            chk_rst = 0;

    // Observations from the most recent cycle.
    logic [N-1:0]  obs_rr;
    logic [DW-1:0] obs_data;
    logic          obs_nd;
    int            n_nd = 0, n_err = 0, n_rr1 = 0;

    function automatic int rr_pick(input logic [N-1:0] v, input int start);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_free = 1; m_wait = 0; m_frame = 0; m_lock = 0;
        m_cnt = 0; m_ptr = 0; m_gid = 0; m_byte = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (p_left[i] > 0 && $urandom_range(99) >= withdraw_pct) begin
                req_valid[i] = 1'b1;
            end else begin
                req_valid[i] = 1'b0;
                if (rand_data) p_data[i] = DW'($urandom);
            end
            req_data[i*DW +: DW] = p_data[i];
            req_lock[i] = lock_mode && (p_left[i] > 1);
        end
        uart_ready = (u_left == 0) && (ext_left == 0);
    endtask

    // One clock cycle: drive, sample mid-cycle, compare, advance the models.
    task automatic cycle(input bit do_rst);
        int g;
        bit ur, acc, exp_err;
        logic [N-1:0] exp_rr;
        drive();
        rst_n = !do_rst;
        #3;
        ur = uart_ready;
        if (chk_rst) begin
            check_eq("rst_uart_data", uart_data, 0);
            check_eq("rst_grant_id", grant_id, 0);
            chk_rst = 0;
        end
        g = -1;
        if (m_free && ur) g = m_lock ? (req_valid[m_gid] ? m_gid : -1) : rr_pick(req_valid, m_ptr);
        exp_rr = (g >= 0) ? (N'(1) << g) : '0;
        check_eq("req_ready", req_ready, exp_rr);
        check_eq("new_data", uart_new_data, m_wait);
        check_eq("busy", busy, m_wait || m_frame);
        exp_err = m_wait && ur && (m_cnt == TO - 1);
        check_eq("err", err, exp_err);
        if (m_wait || m_frame) begin
            check_eq("hold_data", uart_data, m_byte);
            check_eq("grant_id", grant_id, m_gid);
        end
        obs_rr = req_ready; obs_data = uart_data; obs_nd = uart_new_data;
        if (uart_new_data) n_nd++;
        if (err) n_err++;
        if (req_ready[1]) n_rr1++;
        acc = uart_new_data && ur && !stall;
        if (acc) u_log.push_back(uart_data);
        @(posedge clk);
        #1;
        if (acc) u_left = $urandom_range(len_max, len_min);
        else if (u_left > 0) u_left--;
        if (ext_left > 0) ext_left--;
        if (do_rst) begin
            model_reset();
            chk_rst = 1;
        end else if (g >= 0) begin
            m_free = 0; m_wait = 1; m_cnt = 0;
            m_byte = p_data[g]; m_gid = g; m_lock = req_lock[g];
            if (!req_lock[g]) m_ptr = (g + 1) % N;
            grants.push_back(g);
            p_left[g]--;
            if (rand_data) p_data[g] = DW'($urandom);
        end else if (m_wait) begin
            if (!ur) begin
                m_wait = 0; m_frame = 1;
            end else if (exp_err) begin
                m_wait = 0; m_free = 1; m_lock = 0; n_drop++;
            end else begin
                m_cnt++;
            end
        end else if (m_frame) begin
            if (ur) begin
                m_frame = 0; m_free = 1;
            end
        end
        if (rand_mode && m_free && u_left == 0 && ext_left == 0 && $urandom_range(19) == 0)
            ext_left = $urandom_range(4, 1);
    endtask

    task automatic run_until_quiet(input string tag, input int budget);
        int k;
        bit pend;
        k = 0;
        forever begin
            pend = 0;
            for (int i = 0; i < N; i++) if (p_left[i] > 0) pend = 1;
            if (!pend && m_free && u_left == 0) break;
            if (k >= budget) begin
                check_eq(tag, 1, 0);
                break;
            end
            cycle(0);
            k++;
        end
    endtask

    task automatic do_reset();
        cycle(1);
        cycle(1);
        grants.delete();
        u_log.delete();
        n_nd = 0; n_err = 0; n_rr1 = 0; n_drop = 0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < N; i++) begin
            p_left[i] = 0;
            p_data[i] = '0;
        end
        model_reset();

        // Reset state.
        do_reset();
        cycle(0);
        check_eq("reset_busy", obs_nd, 0);

        // Single request from requester 2.
        p_left[2] = 1; p_data[2] = 8'hA5;
        cycle(0);
        check_eq("single_req_ready", obs_rr, 4'b0100);
        cycle(0);
        check_eq("single_uart_data", obs_data, 8'hA5);
        check_eq("single_new_data", obs_nd, 1);
        run_until_quiet("single_timeout", 50);
        check_eq("single_frame_cnt", u_log.size(), 1);
        if (u_log.size() > 0) check_eq("single_frame", u_log[0], 8'hA5);

        // Fairness: everybody continuously valid.
        do_reset();
        len_min = 4; len_max = 4;
        for (int i = 0; i < N; i++) begin
            p_left[i] = 2; p_data[i] = DW'(8'h10 + i);
        end
        run_until_quiet("fair_timeout", 400);
        check_eq("fair_count", grants.size(), 8);
        if (grants.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check_eq("fair_order", grants[i], i % N);
                check_eq("fair_frame", u_log[i], 8'h10 + (i % N));
            end
        end

        // Timeout with a stalled UART.
        do_reset();
        stall = 1;
        p_left[3] = 1; p_data[3] = 8'h3C;
        run_until_quiet("to_timeout", 40);
        check_eq("to_new_data_cycles", n_nd, TO);
        check_eq("to_err_pulses", n_err, 1);
        check_eq("to_dropped", n_drop, 1);
        check_eq("to_idle", busy, 0);
        check_eq("to_no_frame", u_log.size(), 0);
        stall = 0;

        // Reset while a frame is being sent.
        do_reset();
        len_min = 8; len_max = 8;
        p_left[0] = 1; p_data[0] = 8'h5A;
        k = 0;
        while (!m_frame && k < 10) begin cycle(0); k++; end
        check_eq("rst_reach_send", m_frame, 1);
        p_left[1] = 1; p_data[1] = 8'h77;
        cycle(1);
        k = 0;
        while (u_left > 0 && k < 20) begin cycle(0); k++; end
        check_eq("rst_no_early_grant", n_rr1, 0);
        run_until_quiet("rst_timeout", 60);
        check_eq("rst_late_grant", n_rr1, 1);

        // Requester 1 withdraws during a frame.
        do_reset();
        len_min = 10; len_max = 10;
        p_left[0] = 1; p_data[0] = 8'hE1;
        k = 0;
        while (!m_frame && k < 10) begin cycle(0); k++; end
        p_left[1] = 1; p_data[1] = 8'h99;
        repeat (3) cycle(0);
        p_left[1] = 0;
        run_until_quiet("wd_timeout", 60);
        check_eq("wd_no_ready", n_rr1, 0);
        check_eq("wd_grants", grants.size(), 1);

`ifdef UART_TX_ARBITER_LOCK_EN
        // Locked three-byte message from requester 0.
        do_reset();
        len_min = 3; len_max = 3;
        lock_mode = 1;
        p_left[0] = 3; p_data[0] = 8'hC0;
        p_left[1] = 1; p_data[1] = 8'hC1;
        run_until_quiet("lock_timeout", 100);
        check_eq("lock_count", grants.size(), 4);
        if (grants.size() == 4) begin
            check_eq("lock_g0", grants[0], 0);
            check_eq("lock_g1", grants[1], 0);
            check_eq("lock_g2", grants[2], 0);
            check_eq("lock_g3", grants[3], 1);
        end
        lock_mode = 0;
`endif

        // Randomized traffic.
        do_reset();
        len_min = 2; len_max = 6;
        rand_data = 1; rand_mode = 1; withdraw_pct = 25;
        for (int i = 0; i < N; i++) begin
            p_left[i] = $urandom_range(8, 3);
            p_data[i] = DW'($urandom);
        end
        run_until_quiet("rand_timeout", 3000);
        check_eq("rand_all_sent", u_log.size(), grants.size());
        check_eq("rand_no_err", n_err, 0);
        rand_mode = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart` transmitter among `N_REQ` byte producers using round-robin arbitration. Each requester presents a byte with a valid/ready handshake. The arbiter captures the winning byte and drives the UART's `tx_input`/`new_data` inputs. It holds the byte stable for the whole frame and tracks frame completion through the UART's `ready` output. It sits between system-clock producers (debug console, status reporter, etc.) and the single `uart` instance on the board.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `DATA_BITS`, 8: byte width; must match the attached `uart`.
- `TIMEOUT_CYCLES`, 65535: `clk` cycles to wait for the UART to accept a byte before aborting; ≥1.
- `clk` in 1: system clock, same clock as the `uart` instance.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in `N_REQ`: requester *i* has a byte pending.
- `req_data` in `N_REQ*DATA_BITS`: requester *i* byte at bits `[i*DATA_BITS +: DATA_BITS]`.
- `req_ready` out `N_REQ`: one-hot. Bit *i* high means the byte from *i* is captured this cycle.
- `uart_data` out `DATA_BITS`: connects to `uart.tx_input`.
- `uart_new_data` out 1: connects to `uart.new_data`.
- `uart_ready` in 1: from `uart.ready`.
- `busy` out 1: high from capture until frame completion.
- `grant_id` out `$clog2(N_REQ)`: index of the last granted requester.
- `err` out 1: one-cycle pulse on timeout abort.

## Operation
- The FSM has three states: `IDLE`, `START`, `SEND`.
- `IDLE`:
  - If `uart_ready`=1 and any `req_valid`, the round-robin winner *g* is chosen combinationally. The search starts at pointer `ptr` and wraps at `N_REQ`.
  - `req_ready[g]`=1 in the same cycle.
  - At the clock edge: `uart_data`←`req_data[g]`, `grant_id`←g, `ptr`←(g+1) mod `N_REQ`, timeout counter←0, state←`START`.
  - If `uart_ready`=0, no grant is made, even if requests are pending.
- `START`:
  - `uart_new_data`=1 and `busy`=1; the counter increments each cycle.
  - `uart_ready`=0 moves the FSM to `SEND`.
  - If the counter reaches `TIMEOUT_CYCLES`−1 with `uart_ready` still 1: `err` pulses for one cycle, the byte is dropped, and the FSM returns to `IDLE`.
- `SEND`:
  - `uart_new_data`=0 and `busy`=1.
  - `uart_data` is held unchanged, because the UART samples `tx_input` bit by bit during the frame.
  - `uart_ready`=1 moves the FSM to `IDLE`.
- `req_ready` is 0 outside `IDLE`, and is never high for more than one bit.
- A requester must hold `req_valid` and `req_data` until it sees `req_ready`. Dropping `req_valid` before grant withdraws the request.
- Simultaneous requests: only the winner is served. The others stay pending and win in round-robin order.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates.

## Timing
- Reset values: `req_ready`=0, `uart_data`=0, `uart_new_data`=0, `busy`=0, `grant_id`=0, `err`=0, `ptr`=0, state=`IDLE`.
- Grant latency: 0 cycles when `IDLE` and `uart_ready`=1, since `req_ready` is combinational on `req_valid`.
- `uart_new_data` rises 1 cycle after capture.
- After `uart_ready` returns high, the next grant happens in the following cycle. This gives 1 `clk` cycle of gap between frames beyond the UART's own stop bit.
- Reset mid-operation: the FSM returns to `IDLE` and `uart_new_data` drops at that edge. The UART (which has no reset) finishes any frame in progress. The arbiter grants nothing until `uart_ready`=1.
- `uart_ready` falling while in `IDLE` (externally caused) produces no action.

## Configuration
- Macro: `UART_TX_ARBITER_LOCK_EN`.
- When defined:
  - Adds port `req_lock` in `N_REQ`, sampled together with `req_data` at grant.
  - If the lock bit of the granted requester is 1, the next arbitration considers only that requester and `ptr` does not advance. Other requesters wait.
  - The lock releases on a granted byte with lock=0, or on a timeout abort.
  - Used for atomic multi-byte messages.
- When not defined: the port is absent and arbitration is pure round-robin.

## Structure
- Package `uart_pkg` holds:
  - the `uart_arb_state_e` enum (`IDLE`, `START`, `SEND`);
  - a shared `UART_DEFAULT_DATA_BITS` constant.
- Sub-module `rr_arbiter #(N)`:
  - inputs: `req[N]` and `ptr`;
  - outputs: one-hot `gnt[N]` and encoded `gnt_id`;
  - purely combinational.
- Pointer, lock, FSM and counter registers live in `uart_tx_arbiter`.

## Test plan
- Single request: requester 2 sends 0xA5 with `uart_ready`=1. Expect `req_ready`=0b0100 the same cycle, `uart_data`=0xA5 and `uart_new_data`=1 on the next cycle, and the UART line showing frame 0xA5.
- Fairness: all four requesters continuously valid with bytes 0x10/0x11/0x12/0x13. Expect the `grant_id` sequence 0,1,2,3,0. Expect each `uart_data` to be held constant until `uart_ready` rises.
- Timeout: with `TIMEOUT_CYCLES`=8, hold `uart_ready` at 1 (UART stalled). Expect `uart_new_data` high for 8 cycles, `err` pulsing once, and a return to `IDLE`.
- Reset mid-frame: assert `rst_n`=0 during `SEND`. Expect all outputs at reset values next cycle, and no grant until `uart_ready`=1.
- Withdrawn request: requester 1 raises `req_valid` during `SEND` and drops it before `IDLE`. Expect no grant to requester 1 and no `req_ready` activity.
- With `UART_TX_ARBITER_LOCK_EN`: requester 0 sends 3 bytes with lock=1,1,0 while requester 1 is valid throughout. Expect `grant_id` 0,0,0,1.
